// File: rtl/usb3_ep_ram_writer.sv
// Ping-pong packet writer: streams beats into one of two 512-word RAM halves,
// commits good packets to the consumer and drops oversize ones.
module usb3_ep_ram_writer #(
  parameter int BUF_WORDS = 512
) (
  input  logic        wr_clk,
  input  logic        wr_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_dat,
  input  logic        in_last,
  input  logic        in_err,
  output logic        wr_we,
  output logic [9:0]  wr_adr,
  output logic [31:0] wr_dat_w,
  output logic [1:0]  buf_rdy,
  output logic [9:0]  buf_len0,
  output logic [9:0]  buf_len1,
  input  logic [1:0]  buf_done,
  output logic        ovf,
  output logic [15:0] pkt_cnt,
  output logic [1:0]  dbg_state
);

  // Handshake: a beat transfers on a rising wr_clk edge where in_valid and
  // in_ready are both high; in_ready is registered and never depends on in_valid.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam logic [9:0] FULL = 10'(BUF_WORDS);

  state_t      state_q, state_d;
  logic        fill_sel_q, fill_sel_d;
  logic [9:0]  word_idx_q, word_idx_d;
  logic [1:0]  buf_rdy_q, buf_rdy_d;
  logic [9:0]  len0_q, len0_d, len1_q, len1_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic        wr_we_q, wr_we_d;
  logic [9:0]  wr_adr_q, wr_adr_d;
  logic [31:0] wr_dat_q, wr_dat_d;
  logic        in_ready_q, in_ready_d;
  logic        ovf_q, ovf_d;
  logic        accept;

  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d    = state_q;
    fill_sel_d = fill_sel_q;
    word_idx_d = word_idx_q;
    buf_rdy_d  = buf_rdy_q & ~buf_done;
    len0_d     = len0_q;
    len1_d     = len1_q;
    pkt_cnt_d  = pkt_cnt_q;
    wr_we_d    = 1'b0;
    wr_adr_d   = wr_adr_q;
    wr_dat_d   = wr_dat_q;
    ovf_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!buf_rdy_q[fill_sel_q]) begin
          state_d    = S_FILL;
          word_idx_d = 10'd0;
        end
      end
      S_FILL: begin
        if (accept) begin
          if (word_idx_q == FULL) begin
            // 513th beat: the packet is lost either way; only in_last decides
            // whether the tail still has to be swallowed in DROP.
            if (in_last) begin
              ovf_d      = 1'b1;
              word_idx_d = 10'd0;
            end else begin
              state_d = S_DROP;
            end
          end else begin
            wr_we_d    = 1'b1;
            wr_adr_d   = {fill_sel_q, word_idx_q[8:0]};
            wr_dat_d   = in_dat;
            word_idx_d = word_idx_q + 10'd1;
            if (in_last) begin
              word_idx_d = 10'd0;
              if (!in_err) begin
                buf_rdy_d[fill_sel_q] = 1'b1;
                if (fill_sel_q) len1_d = word_idx_q + 10'd1;
                else            len0_d = word_idx_q + 10'd1;
                pkt_cnt_d  = pkt_cnt_q + 16'd1;
                fill_sel_d = ~fill_sel_q;
                state_d    = S_IDLE;
              end
            end
          end
        end
      end
      S_DROP: begin
        if (accept && in_last) begin
          ovf_d      = 1'b1;
          word_idx_d = 10'd0;
          state_d    = S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d != S_IDLE);
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_q    <= S_IDLE;
      fill_sel_q <= 1'b0;
      word_idx_q <= 10'd0;
      buf_rdy_q  <= 2'b00;
      len0_q     <= 10'd0;
      len1_q     <= 10'd0;
      pkt_cnt_q  <= 16'd0;
      wr_we_q    <= 1'b0;
      wr_adr_q   <= 10'd0;
      wr_dat_q   <= 32'd0;
      in_ready_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_sel_q <= fill_sel_d;
      word_idx_q <= word_idx_d;
      buf_rdy_q  <= buf_rdy_d;
      len0_q     <= len0_d;
      len1_q     <= len1_d;
      pkt_cnt_q  <= pkt_cnt_d;
      wr_we_q    <= wr_we_d;
      wr_adr_q   <= wr_adr_d;
      wr_dat_q   <= wr_dat_d;
      in_ready_q <= in_ready_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign wr_we     = wr_we_q;
  assign wr_adr    = wr_adr_q;
  assign wr_dat_w  = wr_dat_q;
  assign buf_rdy   = buf_rdy_q;
  assign buf_len0  = len0_q;
  assign buf_len1  = len1_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: doc/usb3_ep_ram_writer.md
USB3_EP_RAM_WRITER -- requirements
Module: usb3_ep_ram_writer

Interface
REQ-001 Parameter: BUF_WORDS, default 512, words per half-buffer; the only legal value is 512, and bit 9 of the RAM address selects the buffer.
REQ-002 wr_clk  in  1  single clock for all logic.
REQ-003 wr_rst  in  1  reset, asynchronous, active-high.
REQ-004 in_valid  in  1  upstream beat valid.
REQ-005 in_ready  out  1  block accepts beat; a beat transfers when in_valid and in_ready are both high.
REQ-006 in_dat  in  32  beat payload word.
REQ-007 in_last  in  1  final beat of the packet.
REQ-008 in_err  in  1  packet bad; sampled only on the last beat.
REQ-009 wr_we  out  1  RAM write enable.
REQ-010 wr_adr  out  10  RAM write address: {buffer_sel, word_index[8:0]}.
REQ-011 wr_dat_w  out  32  RAM write data.
REQ-012 buf_rdy  out  2  bit i high means buffer i holds a committed packet.
REQ-013 buf_len0  out  10  word count of buffer 0, range 1..512.
REQ-014 buf_len1  out  10  word count of buffer 1, range 1..512.
REQ-015 buf_done  in  2  consumer pulse that frees buffer i.
REQ-016 ovf  out  1  one-cycle pulse: a packet was dropped for exceeding 512 words.
REQ-017 pkt_cnt  out  16  count of committed packets; wraps at 0xFFFF.

Function
REQ-018 The FSM SHALL have three states: IDLE, FILL and DROP; fill_sel (1 bit) SHALL be the buffer being filled.
REQ-019 IDLE: in_ready SHALL be 0; the FSM SHALL go to FILL on the cycle after buf_rdy[fill_sel]==0 is seen, with word_index set to 0.
REQ-020 FILL: in_ready SHALL be 1; each accepted beat SHALL write in_dat into the RAM, and word_index SHALL then increment.
REQ-021 A beat accepted in cycle N SHALL appear at the RAM in cycle N+1: wr_we=1, wr_adr={fill_sel,word_index}, wr_dat_w=in_dat.
REQ-022 wr_we SHALL be 0 in every cycle that does not follow an accepted, stored beat.
REQ-023 Commit: a beat accepted in FILL with in_last=1 and in_err=0 SHALL cause the following updates in cycle N+1:
  - buf_rdy[fill_sel] set;
  - buf_len<fill_sel> set to word_index+1;
  - pkt_cnt incremented;
  - fill_sel toggled;
  - FSM to IDLE.
REQ-024 Error: a last beat with in_err=1 SHALL still be written, but nothing SHALL be committed; word_index SHALL reset to 0 and the FSM SHALL stay in FILL on the same buffer.
REQ-025 Overflow: a beat accepted in FILL when word_index==512 with in_last=0 SHALL NOT be written, and the FSM SHALL enter DROP.
REQ-026 A 512th beat carrying in_last SHALL commit normally, with length 512.
REQ-027 Overflow on the 513th beat: if that beat carries in_last=1, ovf SHALL pulse in N+1 and the FSM SHALL go to FILL with word_index=0 and no DROP visit.
REQ-028 DROP: in_ready SHALL be 1 and no writes SHALL occur; on an accepted in_last, ovf SHALL pulse for one cycle, word_index SHALL reset to 0 and the FSM SHALL return to FILL on the same buffer.
REQ-029 Buffers SHALL be filled in strict alternation 0,1,0,1... so that the consumer sees packets in order.
REQ-030 A buf_done[i] pulse with buf_rdy[i]=1 SHALL clear buf_rdy[i] in the next cycle; a pulse with buf_rdy[i]=0 SHALL be ignored.
REQ-031 When a commit to buffer i and a buf_done[1-i] fall in the same cycle, both SHALL take effect.
REQ-032 buf_len0 and buf_len1 SHALL hold their value until the next commit to that buffer.
REQ-033 When both buffers are ready, in_ready SHALL stay 0 until a buf_done arrives.

Reset
REQ-034 On wr_rst asserted, asynchronously:
  - FSM to IDLE; fill_sel, word_index, buf_rdy, buf_len0, buf_len1, pkt_cnt, wr_we, wr_adr, wr_dat_w all 0;
  - in_ready and ovf 0.
REQ-035 A reset in the middle of a packet SHALL abandon the packet, with no commit and no ovf; the first beat after release SHALL start a new packet in buffer 0.
REQ-036 After release, the first FILL SHALL begin in the second cycle after the reset drops, because IDLE sees buf_rdy==0.

Verification
REQ-037 A 4-beat packet of 0xA0..0xA3 with last on beat 3 -> wr_adr 0x000..0x003 written one cycle later; buf_rdy=01, buf_len0=4, pkt_cnt=1.
REQ-038 Two packets of 3 and 5 words with no buf_done -> buffer 1 used for the second packet at wr_adr 0x200..0x204; buf_rdy=11; a third packet stalls with in_ready=0 until buf_done=01, then fills buffer 0.
REQ-039 A 512-word packet -> buf_len=512 with no ovf; a 600-word packet -> 512 words written, 88 beats dropped, one ovf pulse, buf_rdy unchanged, next packet starts at word_index 0.
REQ-040 A 6-word packet with in_err=1 on the last beat -> 6 writes, no commit; the next 2-word packet commits to the same buffer with len=2.
REQ-041 wr_rst asserted after beat 2 of a packet -> all outputs 0 at once; a packet after release commits to buffer 0 and pkt_cnt=1.
